// File: rtl/index_lut_reader.sv
`default_nettype none
// ============================================================================
//  Module      : index_lut_reader
//  Description : Read-side sequencer for the four intra-prediction index LUTs.
//                Issues a run of consecutive LUT reads, absorbs the 1-cycle
//                ROM latency and streams each 4 x DATA_W index tuple through
//                a small FIFO onto a valid/ready interface. Read issue is
//                throttled so that buffered plus in-flight words never exceed
//                the FIFO depth, so backpressure never drops or repeats data.
//  Revision    : 1.0 - initial release
// ============================================================================
module index_lut_reader #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              angle_or_planar,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              lut_rden,
    output logic [ADDR_W-1:0] lut_address,
    input  logic [DATA_W-1:0] lut_q1,
    input  logic [DATA_W-1:0] lut_q2,
    input  logic [DATA_W-1:0] lut_q3,
    input  logic [DATA_W-1:0] lut_q4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_idx1,
    output logic [DATA_W-1:0] out_idx2,
    output logic [DATA_W-1:0] out_idx3,
    output logic [DATA_W-1:0] out_idx4,
    output logic              out_last,
    output logic              done
);

    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_NEED_W  = c_OCC_W + 2;
    localparam int c_ENTRY_W = 4 * DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_W-1:0]     r_addr;          // address presented to the LUTs
    logic [ADDR_W:0]       r_remaining;     // reads still to be issued
    logic                  r_inflight;      // a read was issued last cycle
    logic                  r_inflight_last; // ... and it was the final one

    logic [c_ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_OCC_W-1:0]    r_occ;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_empty_run;
    logic [c_NEED_W-1:0]   w_need;
    logic [c_ENTRY_W-1:0]  w_head;

    // Returning ROM data is pushed exactly one cycle after its read issue;
    // the consumer pops on a valid/ready handshake.
    assign w_push    = r_inflight;
    assign out_valid = (r_occ != '0);
    assign w_pop     = out_valid & out_ready;

    // A run with nothing to read skips straight to the completion state.
    assign w_empty_run = (count == '0) | ~angle_or_planar;

    // Slots needed if a read is issued now: entries left after this cycle's
    // pop, plus the word returning this cycle, plus the new read.
    assign w_need = c_NEED_W'(r_occ) - c_NEED_W'(w_pop)
                  + c_NEED_W'(r_inflight) + c_NEED_W'(1);
    assign w_room = (w_need <= c_NEED_W'(FIFO_DEPTH));

    assign lut_address = r_addr;

    // Head of FIFO; tuple outputs are forced to zero while nothing is valid
    // so that the stream is clean after reset and between runs.
    assign w_head   = r_mem[r_rptr];
    assign out_idx1 = out_valid ? w_head[1*DATA_W-1:0*DATA_W] : '0;
    assign out_idx2 = out_valid ? w_head[2*DATA_W-1:1*DATA_W] : '0;
    assign out_idx3 = out_valid ? w_head[3*DATA_W-1:2*DATA_W] : '0;
    assign out_idx4 = out_valid ? w_head[4*DATA_W-1:3*DATA_W] : '0;
    assign out_last = out_valid & w_head[c_ENTRY_W-1];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus busy / read-enable / done generation.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        lut_rden    = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_empty_run ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy     = 1'b1;
                lut_rden = w_room;
                if (w_room && (r_remaining == (ADDR_W+1)'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if ((r_occ == '0) && !r_inflight) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Run bookkeeping: address walk (wraps naturally), reads remaining and
    // the in-flight markers that tag the returning word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= lut_rden;
            r_inflight_last <= lut_rden & (r_remaining == (ADDR_W+1)'(1));
            if ((r_state == S_IDLE) && start) begin
                r_addr      <= base_addr;
                r_remaining <= count;
            end else if (lut_rden) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - (ADDR_W+1)'(1);
            end
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide at any level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_W'(1);
                2'b01:   r_occ <= r_occ - c_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy qualifies them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_inflight_last, lut_q4, lut_q3, lut_q2, lut_q1};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_index_lut_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_index_lut_reader
//  Description : Self-checking bench for index_lut_reader with a behavioural
//                ROM, a table of directed runs, a reset-abort sequence and
//                randomized runs with random backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_index_lut_reader;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int c_DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              angle_or_planar = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic              busy, lut_rden, out_valid, out_last, done;
    logic [ADDR_W-1:0] lut_address;
    logic [DATA_W-1:0] lut_q1 = '0, lut_q2 = '0, lut_q3 = '0, lut_q4 = '0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_idx1, out_idx2, out_idx3, out_idx4;

    index_lut_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .angle_or_planar(angle_or_planar),
        .base_addr(base_addr), .count(count), .busy(busy), .lut_rden(lut_rden),
        .lut_address(lut_address), .lut_q1(lut_q1), .lut_q2(lut_q2),
        .lut_q3(lut_q3), .lut_q4(lut_q4), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx1(out_idx1), .out_idx2(out_idx2),
        .out_idx3(out_idx3), .out_idx4(out_idx4), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural LUT contents: index1 in the low byte, index4 in the top.
    logic [31:0] rom [c_DEPTH];

    // Synchronous-read ROM: data appears one clock after rden.
    always @(posedge clk) begin
        if (lut_rden) begin
            {lut_q4, lut_q3, lut_q2, lut_q1} <= rom[lut_address];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit ang;
        int base;
        int cnt;
        int mode;      // 0 ready=1, 1 toggle, 2 held low 20 clks, 3 random
        int exp_done;  // done cycle relative to start, -1 = not fixed
        int exp_beats; // tuples (and reads) expected
    } vec_t;

    // Reference state for the run being observed.
    bit     mon_on = 0;
    int     m_base, m_beats, m_mode;
    int     start_cyc, rel;
    int     reads, beats, first_valid, done_rel;
    bit     done_seen, stall_prev;
    longint prev_tuple, tuple, exp_tuple;

    function automatic bit ready_for(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return t[0];
            2:       return (t > 20);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // Stream monitor: addresses, tuple order/content, last flag, stability
    // under backpressure, outstanding-read bound and done timing.
    always @(negedge clk) begin
        if (mon_on) begin
            rel   = cyc - start_cyc;
            tuple = {out_last, out_idx4, out_idx3, out_idx2, out_idx1};
            if (lut_rden) begin
                chk("rden_addr", lut_address, (m_base + reads) % c_DEPTH);
                reads++;
                chk("rden_excess", reads > m_beats, 0);
            end
            if (stall_prev) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_tuple_stable", tuple, prev_tuple);
            end
            if (out_valid && first_valid < 0) first_valid = rel;
            if (out_valid && out_ready) begin
                if (beats >= m_beats) begin
                    chk("extra_tuple", beats, m_beats - 1);
                end else begin
                    exp_tuple = {(beats == m_beats - 1) ? 1'b1 : 1'b0,
                                 rom[(m_base + beats) % c_DEPTH]};
                    chk("tuple", tuple, exp_tuple);
                end
                beats++;
            end
            chk("outstanding", (reads - beats) > FIFO_DEPTH, 0);
            stall_prev = out_valid && !out_ready;
            prev_tuple = tuple;
            if (m_mode == 2 && rel == 20) chk("stall_reads", reads, FIFO_DEPTH);
            if (done && !done_seen) begin
                done_seen = 1;
                done_rel  = rel;
                chk("busy_at_done", busy, 1);
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int limit;
        m_base = v.base; m_beats = v.exp_beats; m_mode = v.mode;
        reads = 0; beats = 0; first_valid = -1; done_rel = -1;
        done_seen = 0; stall_prev = 0;
        limit = 4 * v.cnt + 100;
        @(posedge clk); #1;
        start = 1'b1; angle_or_planar = v.ang;
        base_addr = ADDR_W'(v.base); count = (ADDR_W+1)'(v.cnt);
        out_ready = ready_for(v.mode, 0);
        start_cyc = cyc;
        mon_on = 1;
        for (int t = 1; t < limit && !done_seen; t++) begin
            @(posedge clk); #1;
            start = (v.mode == 2 && t == 5);
            if (start) begin
                base_addr = ADDR_W'($urandom);
                count     = (ADDR_W+1)'($urandom_range(1, 9));
            end
            out_ready = ready_for(v.mode, t);
        end
        start = 1'b0;
        chk("done_seen", done_seen, 1);
        if (v.exp_done >= 0) chk("done_cycle", done_rel, v.exp_done);
        chk("reads_total", reads, v.exp_beats);
        chk("beats_total", beats, v.exp_beats);
        if (v.exp_beats > 0) chk("first_valid_cycle", first_valid, 3);
        mon_on = 0;
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_clk", done, 0);
        chk("idle_no_valid", out_valid, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rden"}, lut_rden, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_addr"}, lut_address, 0);
        chk({tag, "_idx"}, {out_idx4, out_idx3, out_idx2, out_idx1}, 0);
    endtask

    vec_t tbl [8];
    vec_t rv;

    initial begin
        for (int i = 0; i < c_DEPTH; i++) rom[i] = $urandom;

        //            ang base cnt mode done beats
        tbl[0] = '{1'b1,   0,   4, 0,   7,   4};
        tbl[1] = '{1'b1, 510,   4, 0,   7,   4};
        tbl[2] = '{1'b1,  37,  16, 1,  -1,  16};
        tbl[3] = '{1'b1,   5,   0, 0,   1,   0};
        tbl[4] = '{1'b0,   5,   8, 0,   1,   0};
        tbl[5] = '{1'b1, 300,   8, 2,  -1,   8};
        tbl[6] = '{1'b1, 100, 512, 0, 515, 512};
        tbl[7] = '{1'b1, 511,   1, 0,   4,   1};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // Reset while the FIFO holds data; the following run must be clean.
        @(posedge clk); #1;
        start = 1'b1; angle_or_planar = 1'b1; base_addr = 9'd200;
        count = 10'd16; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_valid", out_valid, 1);
        chk("pre_reset_busy", busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("midrun_reset");
        rv = '{1'b1, 200, 6, 0, 9, 6};
        run_txn(rv);

        // Randomized runs under random backpressure.
        for (int i = 0; i < 40; i++) begin
            rv.ang  = ($urandom_range(0, 4) != 0);
            rv.base = $urandom_range(0, c_DEPTH - 1);
            rv.cnt  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40);
            rv.mode = 3;
            rv.exp_beats = (rv.ang && rv.cnt > 0) ? rv.cnt : 0;
            rv.exp_done  = (rv.exp_beats == 0) ? 1 : -1;
            run_txn(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
